// File: rtl/breath_controller.sv
// Breath controller: triangle-wave LED brightness sequencer with programmable dwell at both
// extremes, driving the LED through a BITS-bit PWM with one clock of output latency.
module breath_controller #(
    parameter int unsigned BITS     = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned HOLD     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    output logic [BITS-1:0] level,
    output logic            dir,
    output logic [1:0]      phase,
    output logic            pwm
);

    localparam int unsigned PrescW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned HoldW    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned HoldLast = (HOLD > 0) ? HOLD - 1 : 0;

    localparam logic [BITS-1:0]   LevelMax  = {BITS{1'b1}};
    localparam logic [PrescW-1:0] PrescLast = PrescW'(PRESCALE - 1);
    localparam logic [HoldW-1:0]  HoldEnd   = HoldW'(HoldLast);

    typedef enum logic [1:0] {
        StRise   = 2'd0,
        StHoldHi = 2'd1,
        StFall   = 2'd2,
        StHoldLo = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [BITS-1:0]   level_q, level_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [PrescW-1:0] presc_q;
    logic [BITS-1:0]   pwm_cnt_q;
    logic              pwm_q;
    logic              tick;

    assign tick = enable && (presc_q == PrescLast);

    // Prescaler, PWM counter and PWM output all freeze while disabled; pwm blanks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_q <= enable && (pwm_cnt_q < level_q);
            if (enable) begin
                presc_q   <= tick ? '0 : presc_q + PrescW'(1);
                pwm_cnt_q <= pwm_cnt_q + BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRise;
            level_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        if (tick) begin
            case (state_q)
                StRise: begin
                    if (level_q != LevelMax) begin
                        level_d = level_q + BITS'(1);
                    end
                    if (level_d == LevelMax) begin
                        state_d = (HOLD == 0) ? StFall : StHoldHi;
                        hold_d  = '0;
                    end
                end
                StHoldHi: begin
                    if (hold_q == HoldEnd) begin
                        state_d = StFall;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
                StFall: begin
                    if (level_q != '0) begin
                        level_d = level_q - BITS'(1);
                    end
                    if (level_d == '0) begin
                        state_d = (HOLD == 0) ? StRise : StHoldLo;
                        hold_d  = '0;
                    end
                end
                StHoldLo: begin
                    if (hold_q == HoldEnd) begin
                        state_d = StRise;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
                end
                default: begin
                    state_d = StRise;
                end
            endcase
        end
    end

    always_comb begin
        phase = state_q;
        dir   = (state_q == StFall) || (state_q == StHoldHi);
        level = level_q;
        pwm   = pwm_q;
    end

endmodule

// File: tb/tb_breath_controller.sv
// Self-checking bench for breath_controller: closed-form reference model of the breathing
// profile indexed by the number of enabled clocks since reset.
module tb_breath_controller;

    localparam int MaxL = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       rst_a = 1'b1, en_a = 1'b0;
    logic [3:0] level_a;
    logic       dir_a, pwm_a;
    logic [1:0] phase_a;
    int         n_a = 0;

    logic       rst_b = 1'b1, en_b = 1'b0;
    logic [3:0] level_b;
    logic       dir_b, pwm_b;
    logic [1:0] phase_b;
    int         n_b = 0;

    logic       rst_c = 1'b1, en_c = 1'b0;
    logic [3:0] level_c;
    logic       dir_c, pwm_c;
    logic [1:0] phase_c;
    int         n_c = 0;

    breath_controller #(.BITS(4), .PRESCALE(2), .HOLD(2)) dut_a (
        .clk(clk), .rst_n(rst_a), .enable(en_a),
        .level(level_a), .dir(dir_a), .phase(phase_a), .pwm(pwm_a)
    );

    breath_controller #(.BITS(4), .PRESCALE(2), .HOLD(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .enable(en_b),
        .level(level_b), .dir(dir_b), .phase(phase_b), .pwm(pwm_b)
    );

    breath_controller #(.BITS(4), .PRESCALE(40), .HOLD(2)) dut_c (
        .clk(clk), .rst_n(rst_c), .enable(en_c),
        .level(level_c), .dir(dir_c), .phase(phase_c), .pwm(pwm_c)
    );

    // Position within the breathing cycle, in ticks, after n enabled clocks.
    function automatic int ref_pos(input int n, input int presc, input int hold);
        return (n / presc) % (2 * MaxL + 2 * hold);
    endfunction

    function automatic int ref_level(input int n, input int presc, input int hold);
        int p = ref_pos(n, presc, hold);
        if (p < MaxL) return p;
        if (p < MaxL + hold) return MaxL;
        if (p < 2 * MaxL + hold) return MaxL - (p - MaxL - hold);
        return 0;
    endfunction

    function automatic int ref_phase(input int n, input int presc, input int hold);
        int p = ref_pos(n, presc, hold);
        if (p < MaxL) return 0;
        if (p < MaxL + hold) return 1;
        if (p < 2 * MaxL + hold) return 2;
        return 3;
    endfunction

    // pwm after an enabled edge reflects counter and level as they were before that edge.
    function automatic logic ref_pwm(input int nb, input int presc, input int hold);
        return (nb % 16) < ref_level(nb, presc, hold);
    endfunction

    task automatic reset_a();
        rst_a = 1'b0; en_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1; n_a = 0;
    endtask

    task automatic reset_b();
        rst_b = 1'b0; en_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1; n_b = 0;
    endtask

    task automatic reset_c();
        rst_c = 1'b0; en_c = 1'b0;
        repeat (2) @(negedge clk);
        rst_c = 1'b1; n_c = 0;
    endtask

    task automatic step_a(input logic en, output int nb);
        @(negedge clk); en_a = en;
        @(posedge clk); #1;
        nb = n_a;
        if (en) n_a++;
    endtask

    task automatic step_b(input logic en, output int nb);
        @(negedge clk); en_b = en;
        @(posedge clk); #1;
        nb = n_b;
        if (en) n_b++;
    endtask

    task automatic step_c(input logic en, output int nb);
        @(negedge clk); en_c = en;
        @(posedge clk); #1;
        nb = n_c;
        if (en) n_c++;
    endtask

    task automatic test_reset();
        #2;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #1;
        checks++;
        if (level_a !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_a); end
        checks++;
        if (phase_a !== 2'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase_a); end
        checks++;
        if (dir_a !== 1'b0) begin errors++; $display("FAIL reset_dir got=%0b exp=0", dir_a); end
        checks++;
        if (pwm_a !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%0b exp=0", pwm_a); end
        checks++;
        if (level_b !== 4'd0 || level_c !== 4'd0) begin
            errors++; $display("FAIL reset_level_bc got=%0d,%0d exp=0", level_b, level_c);
        end
    endtask

    task automatic test_profile();
        int nb;
        int prev;
        reset_a();
        prev = 0;
        for (int i = 0; i < 140; i++) begin
            step_a(1'b1, nb);
            checks++;
            if (level_a !== 4'(ref_level(n_a, 2, 2))) begin
                errors++;
                $display("FAIL profile_level n=%0d got=%0d exp=%0d", n_a, level_a,
                         ref_level(n_a, 2, 2));
            end
            checks++;
            if (phase_a !== 2'(ref_phase(n_a, 2, 2))) begin
                errors++;
                $display("FAIL profile_phase n=%0d got=%0d exp=%0d", n_a, phase_a,
                         ref_phase(n_a, 2, 2));
            end
            checks++;
            if (dir_a !== (ref_phase(n_a, 2, 2) == 1 || ref_phase(n_a, 2, 2) == 2)) begin
                errors++; $display("FAIL profile_dir n=%0d got=%0b", n_a, dir_a);
            end
            checks++;
            if (pwm_a !== ref_pwm(nb, 2, 2)) begin
                errors++;
                $display("FAIL profile_pwm n=%0d got=%0b exp=%0b", n_a, pwm_a, ref_pwm(nb, 2, 2));
            end
            // Level moves by at most one step, and only on tick edges.
            checks++;
            if ((int'(level_a) - prev > 1) || (prev - int'(level_a) > 1) ||
                ((nb % 2 == 0) && (int'(level_a) != prev))) begin
                errors++;
                $display("FAIL profile_step n=%0d got=%0d prev=%0d", n_a, level_a, prev);
            end
            prev = int'(level_a);
            if (n_a == 30) begin
                checks++;
                if (level_a !== 4'd15 || phase_a !== 2'd1) begin
                    errors++;
                    $display("FAIL clk30 got level=%0d phase=%0d exp 15/1", level_a, phase_a);
                end
            end
            if (n_a == 34) begin
                checks++;
                if (phase_a !== 2'd2 || dir_a !== 1'b1) begin
                    errors++;
                    $display("FAIL clk34 got phase=%0d dir=%0b exp 2/1", phase_a, dir_a);
                end
            end
            if (n_a == 64) begin
                checks++;
                if (level_a !== 4'd0 || phase_a !== 2'd3) begin
                    errors++;
                    $display("FAIL clk64 got level=%0d phase=%0d exp 0/3", level_a, phase_a);
                end
            end
            if (n_a == 68) begin
                checks++;
                if (phase_a !== 2'd0) begin
                    errors++; $display("FAIL clk68 got phase=%0d exp 0", phase_a);
                end
            end
        end
    endtask

    task automatic test_random_enable();
        int   nb;
        logic en;
        reset_a();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            step_a(en, nb);
            checks++;
            if (level_a !== 4'(ref_level(n_a, 2, 2)) || phase_a !== 2'(ref_phase(n_a, 2, 2))) begin
                errors++;
                $display("FAIL rand_state n=%0d got=%0d/%0d exp=%0d/%0d", n_a, level_a, phase_a,
                         ref_level(n_a, 2, 2), ref_phase(n_a, 2, 2));
            end
            checks++;
            if (pwm_a !== (en && ref_pwm(nb, 2, 2))) begin
                errors++;
                $display("FAIL rand_pwm n=%0d en=%0b got=%0b exp=%0b", n_a, en, pwm_a,
                         en && ref_pwm(nb, 2, 2));
            end
        end
    endtask

    task automatic test_freeze();
        int nb;
        reset_a();
        repeat (11) step_a(1'b1, nb);
        checks++;
        if (level_a !== 4'd5 || phase_a !== 2'd0) begin
            errors++;
            $display("FAIL freeze_setup got level=%0d phase=%0d exp 5/0", level_a, phase_a);
        end
        for (int i = 0; i < 10; i++) begin
            step_a(1'b0, nb);
            checks++;
            if (level_a !== 4'd5 || phase_a !== 2'd0 || pwm_a !== 1'b0) begin
                errors++;
                $display("FAIL freeze_hold i=%0d got level=%0d phase=%0d pwm=%0b exp 5/0/0", i,
                         level_a, phase_a, pwm_a);
            end
        end
        // One prescale count was left before the freeze, so the first enabled clock ticks.
        step_a(1'b1, nb);
        checks++;
        if (level_a !== 4'd6) begin
            errors++; $display("FAIL freeze_resume got level=%0d exp 6", level_a);
        end
        step_a(1'b1, nb);
        checks++;
        if (level_a !== 4'd6) begin
            errors++; $display("FAIL freeze_resume_next got level=%0d exp 6", level_a);
        end
    endtask

    task automatic test_hold0();
        int nb;
        reset_b();
        for (int i = 0; i < 130; i++) begin
            step_b(1'b1, nb);
            checks++;
            if (phase_b === 2'd1 || phase_b === 2'd3) begin
                errors++; $display("FAIL hold0_phase n=%0d got=%0d", n_b, phase_b);
            end
            checks++;
            if (level_b !== 4'(ref_level(n_b, 2, 0)) || phase_b !== 2'(ref_phase(n_b, 2, 0))) begin
                errors++;
                $display("FAIL hold0_state n=%0d got=%0d/%0d exp=%0d/%0d", n_b, level_b, phase_b,
                         ref_level(n_b, 2, 0), ref_phase(n_b, 2, 0));
            end
            if (n_b == 30) begin
                checks++;
                if (level_b !== 4'd15 || phase_b !== 2'd2) begin
                    errors++;
                    $display("FAIL hold0_peak got level=%0d phase=%0d exp 15/2", level_b, phase_b);
                end
            end
            if (n_b == 60) begin
                checks++;
                if (level_b !== 4'd0 || phase_b !== 2'd0) begin
                    errors++;
                    $display("FAIL hold0_period got level=%0d phase=%0d exp 0/0", level_b, phase_b);
                end
            end
        end
    endtask

    task automatic test_pwm_half();
        int nb;
        int highs;
        reset_c();
        repeat (320) step_c(1'b1, nb);
        checks++;
        if (level_c !== 4'd8) begin
            errors++; $display("FAIL half_setup got level=%0d exp 8", level_c);
        end
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            step_c(1'b1, nb);
            if (pwm_c === 1'b1) highs++;
            checks++;
            if (pwm_c !== ((nb % 16) < 8)) begin
                errors++;
                $display("FAIL half_lag cnt=%0d got=%0b exp=%0b", nb % 16, pwm_c, (nb % 16) < 8);
            end
        end
        checks++;
        if (highs != 16) begin
            errors++; $display("FAIL half_duty got=%0d exp=16 of 32", highs);
        end
    endtask

    task automatic test_async_reset();
        int nb;
        reset_a();
        repeat (46) step_a(1'b1, nb);
        checks++;
        if (level_a !== 4'd9 || phase_a !== 2'd2) begin
            errors++;
            $display("FAIL arst_setup got level=%0d phase=%0d exp 9/2", level_a, phase_a);
        end
        #2 rst_a = 1'b0;
        #1;
        checks++;
        if (level_a !== 4'd0 || phase_a !== 2'd0 || pwm_a !== 1'b0 || dir_a !== 1'b0) begin
            errors++;
            $display("FAIL arst_clear got level=%0d phase=%0d pwm=%0b dir=%0b exp 0", level_a,
                     phase_a, pwm_a, dir_a);
        end
    endtask

    initial begin
        test_reset();
        test_profile();
        test_random_enable();
        test_freeze();
        test_hold0();
        test_pwm_half();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
